adc_acq_scheduler: RTL and testbench
====================================

// Module: adc_acq_scheduler
// PURPOSE
//  Sequences the ADS8864 serial ADC interface for timed sample bursts: issues conversion starts at a
//  programmed period, collects each result and writes it to the sample RAM at an incrementing address.
//  Sits between the OPB register file (control/status at 0x800/0x808) and the ADC interface core.
//  Replaces software-paced starts with a fixed-rate, self-terminating or continuous acquisition.
// PARAMETERS
//  DATA_W   16     ADC sample width
//  ADDR_W   10     sample RAM address width (DEPTH = 2**ADDR_W)
//  PER_W    20     width of CFG_PERIOD (OPB_CLK cycles between conversion starts)
//  TMO_CYC  4096   max cycles in WAIT_DONE before timeout
// PORTS
//  OPB_CLK     in   1          sole clock
//  OPB_RST_N   in   1          asynchronous reset, active low
//  START_REQ   in   1          1-cycle pulse: begin a run (ignored unless IDLE)
//  ABORT       in   1          1-cycle pulse: terminate run immediately
//  CFG_PERIOD  in   PER_W      start-to-start period; 0 or 1 = back-to-back
//  CFG_COUNT   in   ADDR_W+1   samples per run; 0 = continuous until ABORT
//  STAT_CLR    in   1          clears sticky STAT_DONE/OVR/TMO
//  ADC_START   out  1          1-cycle conversion request to ADC interface
//  ADC_DONE    in   1          1-cycle pulse, ADC_DATA valid same cycle
//  ADC_DATA    in   DATA_W     conversion result
//  RAM_WE      out  1          sample RAM write strobe
//  RAM_ADDR    out  ADDR_W     sample RAM write address
//  RAM_WDATA   out  DATA_W     sample RAM write data
//  STAT_BUSY   out  1          run in progress (state != IDLE)
//  STAT_DONE   out  1          sticky: run completed CFG_COUNT samples
//  STAT_OVR    out  1          sticky: period elapsed before previous sample stored
//  STAT_TMO    out  1          sticky: ADC_DONE timeout, run aborted
//  STAT_CNT    out  ADDR_W+1   samples written this run, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, address/period/timeout counters 0.
//  FSM: IDLE -START_REQ-> START; START (ADC_START=1, load period ctr = CFG_PERIOD-1) -> WAIT_DONE;
//   WAIT_DONE -ADC_DONE-> STORE (latch ADC_DATA); STORE (RAM_WE=1, addr++, cnt++) ->
//   IDLE if CFG_COUNT!=0 and cnt reaches CFG_COUNT (set STAT_DONE), else GAP; GAP -period ctr==0-> START.
//  Latency: START_REQ cycle n -> ADC_START cycle n+1; ADC_DONE cycle m -> RAM_WE cycle m+1.
//  Run start clears RAM_ADDR, STAT_CNT, STAT_DONE; CFG_* sampled once at START_REQ and held for the run.
//  Period ctr free-runs from each START; if it hits 0 while in WAIT_DONE/STORE: set STAT_OVR,
//   go STORE->START directly (start deferred, never dropped). Period 0/1: back-to-back, OVR never set.
//  RAM_ADDR wraps DEPTH-1 -> 0 (continuous mode); STAT_CNT saturates at all-ones.
//  Timeout: WAIT_DONE > TMO_CYC cycles -> STAT_TMO=1, IDLE, no write, STAT_DONE stays 0.
//  ABORT: any state -> IDLE next cycle; a late ADC_DONE is ignored; written samples remain valid.
//  ADC_DONE outside WAIT_DONE ignored. START_REQ while busy ignored.
//  Same cycle: ABORT beats START_REQ and pending STORE; set beats STAT_CLR for each sticky bit.
//  Reset mid-run: immediate return to reset state, ADC_START deasserts asynchronously.
// CONFIGURATION
//  ADC_SCHED_EXT_TRIG_EN defined: adds input EXT_TRIG (async); 2-flop sync + rising-edge detect;
//   in GAP a detected edge also starts the next conversion (whichever of edge/period first),
//   in IDLE an edge acts as START_REQ; edges in other states are dropped and set STAT_OVR.
//  Not defined: no EXT_TRIG port, timing solely from CFG_PERIOD.
// STRUCTURE
//  adc_sched_pkg: state enum (IDLE, START, WAIT_DONE, STORE, GAP), DATA_W/ADDR_W defaults,
//   STAT_* bit positions in the 0x808 status word.
//  Sub-module adc_sched_trig_sync (synchroniser + edge detect), instantiated only with the macro.
// TESTING
//  CFG_COUNT=4, CFG_PERIOD=200, model DONE 100 cycles after START -> 4 ADC_START 200 apart,
//   RAM writes addr 0..3 with model data, STAT_DONE=1, STAT_CNT=4, BUSY low after last write.
//  CFG_PERIOD=50, DONE latency 100 -> STAT_OVR=1, every start issued the cycle after STORE, no loss.
//  CFG_COUNT=0, ADDR_W=3, 10 samples then ABORT -> addr sequence 0..7,0,1; IDLE next cycle, STAT_DONE=0.
//  Model never returns DONE -> STAT_TMO=1 after TMO_CYC cycles, IDLE, no RAM_WE.
//  ABORT during WAIT_DONE, DONE 3 cycles later -> no write; START_REQ+ABORT same cycle -> stays IDLE.
//  With ADC_SCHED_EXT_TRIG_EN, CFG_PERIOD=1000, EXT_TRIG edge every 300 -> starts track edges
//   (3-4 cycle sync delay); edge during WAIT_DONE -> STAT_OVR=1.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC acquisition scheduler:
// FSM state encoding, default widths and status-word bit positions.
package adc_sched_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_PER_W   = 20;
    localparam int DEF_TMO_CYC = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        STORE     = 3'd3,
        GAP       = 3'd4
    } state_e;

    // Bit positions of the sticky/status flags in the 0x808 status word
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_OVR_BIT  = 2;
    localparam int STAT_TMO_BIT  = 3;
    localparam int STAT_W        = 4;

endpackage

// File: rtl/adc_sched_trig_sync.sv
// Two-flop synchroniser plus rising-edge detector for the asynchronous
// external trigger; only instantiated when ADC_SCHED_EXT_TRIG_EN is defined.
module adc_sched_trig_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic trig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/adc_acq_scheduler.sv
// Fixed-rate ADC conversion scheduler: issues starts every CFG_PERIOD cycles and
// stores each result at an incrementing RAM address. Optional macro: ADC_SCHED_EXT_TRIG_EN.
//
// state     | meaning
// IDLE      | no run; waiting for START_REQ (or an external trigger edge)
// START     | ADC_START asserted for one cycle, period/timeout timers loaded
// WAIT_DONE | waiting for ADC_DONE, timeout timer counting down
// STORE     | RAM_WE with latched sample, address/count advance
// GAP       | waiting for the period timer (or trigger edge) before next start
module adc_acq_scheduler
    import adc_sched_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PER_W   = DEF_PER_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST_N,
`ifdef ADC_SCHED_EXT_TRIG_EN
    input  logic              EXT_TRIG,
`endif
    input  logic              START_REQ,
    input  logic              ABORT,
    input  logic [PER_W-1:0]  CFG_PERIOD,
    input  logic [ADDR_W:0]   CFG_COUNT,
    input  logic              STAT_CLR,
    output logic              ADC_START,
    input  logic              ADC_DONE,
    input  logic [DATA_W-1:0] ADC_DATA,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    output logic              STAT_BUSY,
    output logic              STAT_DONE,
    output logic              STAT_OVR,
    output logic              STAT_TMO,
    output logic [ADDR_W:0]   STAT_CNT
);

    localparam int                TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TMO_CYC - 1);
    localparam logic [ADDR_W:0]   CNT_MAX  = {(ADDR_W + 1){1'b1}};

    state_e              state_q, state_d;
    logic [PER_W-1:0]    cfg_period_q, cfg_period_d;
    logic [ADDR_W:0]     cfg_count_q, cfg_count_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic                tmo_q, tmo_d;

    logic                trig_rise;
    logic                per_tc;
    logic                per_chk;
    logic [PER_W-1:0]    per_load;
    logic [ADDR_W:0]     cnt_inc;
    logic                done_set, ovr_set, tmo_set, run_clr;
    logic [STAT_W-1:0]   stat_word;

`ifdef ADC_SCHED_EXT_TRIG_EN
    adc_sched_trig_sync u_trig_sync (
        .clk_i   (OPB_CLK),
        .rst_n_i (OPB_RST_N),
        .trig_i  (EXT_TRIG),
        .rise_o  (trig_rise)
    );
`else
    assign trig_rise = 1'b0;
`endif

    // The period timer "expires" on the cycle it reaches zero, so a start
    // issued from GAP lands exactly CFG_PERIOD cycles after the previous one.
    assign per_tc   = (per_cnt_q <= PER_W'(1));
    assign per_chk  = (cfg_period_q > PER_W'(1));
    assign per_load = (cfg_period_q == '0) ? '0 : cfg_period_q - PER_W'(1);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d      = state_q;
        cfg_period_d = cfg_period_q;
        cfg_count_d  = cfg_count_q;
        per_cnt_d    = (per_cnt_q != '0) ? per_cnt_q - PER_W'(1) : '0;
        tmo_cnt_d    = tmo_cnt_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        done_set     = 1'b0;
        ovr_set      = 1'b0;
        tmo_set      = 1'b0;
        run_clr      = 1'b0;

        if (ABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START_REQ || trig_rise) begin
                        state_d      = START;
                        cfg_period_d = CFG_PERIOD;
                        cfg_count_d  = CFG_COUNT;
                        addr_d       = '0;
                        cnt_d        = '0;
                        run_clr      = 1'b1;
                    end
                end
                START: begin
                    state_d   = WAIT_DONE;
                    per_cnt_d = per_load;
                    tmo_cnt_d = TMO_LOAD;
                    ovr_set   = trig_rise;
                end
                WAIT_DONE: begin
                    ovr_set = (per_tc && per_chk) || trig_rise;
                    if (ADC_DONE) begin
                        state_d = STORE;
                        data_d  = ADC_DATA;
                    end else if (tmo_cnt_q == '0) begin
                        state_d = IDLE;
                        tmo_set = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                    end
                end
                STORE: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_inc;
                    ovr_set = trig_rise;
                    if ((cfg_count_q != '0) && (cnt_inc == cfg_count_q)) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end else if (per_tc) begin
                        // Deferred start: the period already ran out while waiting
                        state_d = START;
                    end else begin
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (per_tc || trig_rise) begin
                        state_d = START;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        done_d = done_set | (done_q & ~STAT_CLR & ~run_clr);
        ovr_d  = ovr_set  | (ovr_q  & ~STAT_CLR);
        tmo_d  = tmo_set  | (tmo_q  & ~STAT_CLR);
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q      <= IDLE;
            cfg_period_q <= '0;
            cfg_count_q  <= '0;
            per_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_period_q <= cfg_period_d;
            cfg_count_q  <= cfg_count_d;
            per_cnt_q    <= per_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            tmo_q        <= tmo_d;
        end
    end

    assign stat_word[STAT_BUSY_BIT] = (state_q != IDLE);
    assign stat_word[STAT_DONE_BIT] = done_q;
    assign stat_word[STAT_OVR_BIT]  = ovr_q;
    assign stat_word[STAT_TMO_BIT]  = tmo_q;

    // Decoded from the state register so reset drops ADC_START asynchronously
    assign ADC_START = (state_q == START);
    assign RAM_WE    = (state_q == STORE);
    assign RAM_ADDR  = addr_q;
    assign RAM_WDATA = data_q;
    assign STAT_BUSY = stat_word[STAT_BUSY_BIT];
    assign STAT_DONE = stat_word[STAT_DONE_BIT];
    assign STAT_OVR  = stat_word[STAT_OVR_BIT];
    assign STAT_TMO  = stat_word[STAT_TMO_BIT];
    assign STAT_CNT  = cnt_q;

endmodule

// File: tb/tb_adc_acq_scheduler.sv
// Scoreboard bench for adc_acq_scheduler with a behavioural ADC model.
module tb_adc_acq_scheduler;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int PER_W   = 20;
    localparam int TMO_CYC = 4096;

    logic              OPB_CLK;
    logic              OPB_RST_N;
`ifdef ADC_SCHED_EXT_TRIG_EN
    logic              EXT_TRIG;
`endif
    logic              START_REQ;
    logic              ABORT;
    logic [PER_W-1:0]  CFG_PERIOD;
    logic [ADDR_W:0]   CFG_COUNT;
    logic              STAT_CLR;
    logic              ADC_START;
    logic              ADC_DONE;
    logic [DATA_W-1:0] ADC_DATA;
    logic              RAM_WE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic              STAT_BUSY;
    logic              STAT_DONE;
    logic              STAT_OVR;
    logic              STAT_TMO;
    logic [ADDR_W:0]   STAT_CNT;

    adc_acq_scheduler #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PER_W  (PER_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .OPB_CLK    (OPB_CLK),
        .OPB_RST_N  (OPB_RST_N),
`ifdef ADC_SCHED_EXT_TRIG_EN
        .EXT_TRIG   (EXT_TRIG),
`endif
        .START_REQ  (START_REQ),
        .ABORT      (ABORT),
        .CFG_PERIOD (CFG_PERIOD),
        .CFG_COUNT  (CFG_COUNT),
        .STAT_CLR   (STAT_CLR),
        .ADC_START  (ADC_START),
        .ADC_DONE   (ADC_DONE),
        .ADC_DATA   (ADC_DATA),
        .RAM_WE     (RAM_WE),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_WDATA  (RAM_WDATA),
        .STAT_BUSY  (STAT_BUSY),
        .STAT_DONE  (STAT_DONE),
        .STAT_OVR   (STAT_OVR),
        .STAT_TMO   (STAT_TMO),
        .STAT_CNT   (STAT_CNT)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wr_cnt = 0;
    int  last_done_cyc = -100;
    int  mdl_lat = 10;
    int  mdl_epoch = 0;
    bit  mdl_mute = 1'b0;
    wr_t exp_q[$];
    int  st_q[$];

    initial begin
        OPB_CLK = 1'b0;
        forever #5 OPB_CLK = ~OPB_CLK;
    end

    initial begin
        forever begin
            @(posedge OPB_CLK);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ADC model: DONE mdl_lat cycles after each ADC_START, data = {epoch, sample index}
    initial begin
        int dcnt;
        int k;
        int ep;
        dcnt = 0;
        k = 0;
        ep = -1;
        ADC_DONE = 1'b0;
        ADC_DATA = '0;
        forever begin
            @(posedge OPB_CLK);
            #1;
            if (ep != mdl_epoch) begin
                ep = mdl_epoch;
                k = 0;
            end
            ADC_DONE = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    ADC_DONE = 1'b1;
                    ADC_DATA = {mdl_epoch[7:0], k[7:0]};
                    k++;
                    last_done_cyc = cyc;
                end
            end
            if (ADC_START && !mdl_mute) dcnt = mdl_lat;
        end
    end

    // Monitor: record starts, pop and compare every RAM write
    initial begin
        wr_t e;
        forever begin
            @(negedge OPB_CLK);
            if (ADC_START) st_q.push_back(cyc);
            if (RAM_WE) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", RAM_ADDR, RAM_WDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(RAM_ADDR), 32'(e.addr));
                    chk("wr_data", 32'(RAM_WDATA), 32'(e.data));
                    chk("we_latency", cyc, last_done_cyc + 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge OPB_CLK);
        #1;
    endtask

    task automatic start_run(input int cnt, input int per, input int lat, output int req_cyc);
        mdl_epoch++;
        mdl_lat = lat;
        CFG_COUNT = (ADDR_W + 1)'(cnt);
        CFG_PERIOD = PER_W'(per);
        st_q.delete();
        START_REQ = 1'b1;
        req_cyc = cyc;
        step(1);
        START_REQ = 1'b0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(wr_t'({ADDR_W'(i), mdl_epoch[7:0], 8'(i)}));
    endtask

    task automatic wait_idle(input string name, input int max, output int idle_cyc);
        int n;
        n = 0;
        do begin
            @(negedge OPB_CLK);
            n++;
        end while (STAT_BUSY && n < max);
        idle_cyc = cyc;
        if (STAT_BUSY) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: got busy after %0d cycles, expected idle", name, max);
        end
    endtask

    task automatic clear_stat();
        STAT_CLR = 1'b1;
        step(1);
        STAT_CLR = 1'b0;
    endtask

    task automatic run_cont(input string tag, input int n, input int per, input int lat, input int exp_cnt);
        int base;
        int guard;
        int rq;
        base = wr_cnt;
        start_run(0, per, lat, rq);
        push_exp(n);
        guard = 0;
        while (wr_cnt < base + n && guard < 5000) begin
            step(1);
            guard++;
        end
        chk({tag, "_nwrites"}, wr_cnt - base, n);
        ABORT = 1'b1;
        step(1);
        ABORT = 1'b0;
        @(negedge OPB_CLK);
        chk({tag, "_busy_after_abort"}, 32'(STAT_BUSY), 0);
        chk({tag, "_done"}, 32'(STAT_DONE), 0);
        chk({tag, "_cnt"}, 32'(STAT_CNT), exp_cnt);
        step(20);
        chk({tag, "_late_writes"}, wr_cnt - base, n);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int rq;
        int ic;
        int base;
        int nst;
        OPB_RST_N = 1'b0;
        START_REQ = 1'b0;
        ABORT = 1'b0;
        STAT_CLR = 1'b0;
        CFG_PERIOD = '0;
        CFG_COUNT = '0;
`ifdef ADC_SCHED_EXT_TRIG_EN
        EXT_TRIG = 1'b0;
`endif
        step(3);
        @(negedge OPB_CLK);
        chk("rst_adc_start", 32'(ADC_START), 0);
        chk("rst_ram_we", 32'(RAM_WE), 0);
        chk("rst_ram_addr", 32'(RAM_ADDR), 0);
        chk("rst_ram_wdata", 32'(RAM_WDATA), 0);
        chk("rst_status", {STAT_BUSY, STAT_DONE, STAT_OVR, STAT_TMO}, 0);
        chk("rst_cnt", 32'(STAT_CNT), 0);
        step(1);
        OPB_RST_N = 1'b1;
        step(2);

        // Counted run, period longer than conversion
        start_run(4, 200, 100, rq);
        push_exp(4);
        step(250);
        START_REQ = 1'b1;
        step(1);
        START_REQ = 1'b0;
        wait_idle("t2", 1500, ic);
        chk("t2_nstarts", st_q.size(), 4);
        if (st_q.size() == 4) begin
            chk("t2_first_start", st_q[0], rq + 1);
            for (int i = 1; i < 4; i++) chk("t2_interval", st_q[i] - st_q[i-1], 200);
        end
        chk("t2_idle_cycle", ic, rq + 1 + 702);
        chk("t2_done", 32'(STAT_DONE), 1);
        chk("t2_cnt", 32'(STAT_CNT), 4);
        chk("t2_ovr", 32'(STAT_OVR), 0);
        chk("t2_queue_empty", exp_q.size(), 0);
        step(5);

        // Overrun: period shorter than conversion latency
        start_run(4, 50, 100, rq);
        push_exp(4);
        wait_idle("t3", 1500, ic);
        chk("t3_nstarts", st_q.size(), 4);
        if (st_q.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("t3_interval", st_q[i] - st_q[i-1], 102);
        end
        chk("t3_ovr", 32'(STAT_OVR), 1);
        chk("t3_done", 32'(STAT_DONE), 1);
        chk("t3_cnt", 32'(STAT_CNT), 4);
        step(1);
        clear_stat();
        @(negedge OPB_CLK);
        chk("clr_ovr", 32'(STAT_OVR), 0);
        chk("clr_done", 32'(STAT_DONE), 0);
        step(3);

        // Continuous mode with address wrap, then count saturation
        run_cont("t4", 10, 0, 4, 10);
        run_cont("t5", 17, 1, 2, 15);
        chk("t5_ovr", 32'(STAT_OVR), 0);

        // Timeout: ADC never answers
        mdl_mute = 1'b1;
        base = wr_cnt;
        start_run(2, 0, 5, rq);
        wait_idle("t6", TMO_CYC + 200, ic);
        chk("t6_idle_cycle", ic, rq + 1 + TMO_CYC + 1);
        chk("t6_tmo", 32'(STAT_TMO), 1);
        chk("t6_done", 32'(STAT_DONE), 0);
        chk("t6_writes", wr_cnt - base, 0);
        mdl_mute = 1'b0;
        step(1);
        clear_stat();
        @(negedge OPB_CLK);
        chk("clr_tmo", 32'(STAT_TMO), 0);
        step(2);

        // Abort in WAIT_DONE, DONE arrives 3 cycles later
        base = wr_cnt;
        start_run(1, 0, 20, rq);
        step(17);
        ABORT = 1'b1;
        step(1);
        ABORT = 1'b0;
        @(negedge OPB_CLK);
        chk("t7_busy", 32'(STAT_BUSY), 0);
        step(10);
        chk("t7_writes", wr_cnt - base, 0);
        chk("t7_cnt", 32'(STAT_CNT), 0);
        chk("t7_done", 32'(STAT_DONE), 0);

        // START_REQ and ABORT in the same cycle
        nst = st_q.size();
        START_REQ = 1'b1;
        ABORT = 1'b1;
        step(1);
        START_REQ = 1'b0;
        ABORT = 1'b0;
        @(negedge OPB_CLK);
        chk("t8_busy", 32'(STAT_BUSY), 0);
        step(5);
        chk("t8_starts", st_q.size(), nst);

        // Reset in the middle of a run drops ADC_START immediately
        start_run(2, 0, 30, rq);
        #2;
        OPB_RST_N = 1'b0;
        #1;
        chk("t9_adc_start_async", 32'(ADC_START), 0);
        chk("t9_busy", 32'(STAT_BUSY), 0);
        step(2);
        OPB_RST_N = 1'b1;
        step(40);
        chk("t9_cnt", 32'(STAT_CNT), 0);

`ifdef ADC_SCHED_EXT_TRIG_EN
        begin
            int e1;
            int e2;
            start_run(3, 1000, 20, rq);
            push_exp(3);
            step(299);
            e1 = cyc;
            EXT_TRIG = 1'b1;
            step(10);
            EXT_TRIG = 1'b0;
            step(290);
            e2 = cyc;
            EXT_TRIG = 1'b1;
            step(4);
            EXT_TRIG = 1'b0;
            step(4);
            EXT_TRIG = 1'b1;
            wait_idle("tx", 500, ic);
            EXT_TRIG = 1'b0;
            chk("tx_nstarts", st_q.size(), 3);
            if (st_q.size() == 3) begin
                chk("tx_start1", st_q[1], e1 + 3);
                chk("tx_start2", st_q[2], e2 + 3);
            end
            chk("tx_ovr", 32'(STAT_OVR), 1);
            chk("tx_done", 32'(STAT_DONE), 1);
            step(10);
        end
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
